// File: rtl/stack_ctrl_pkg.sv
// Shared codes for the stack controller: command encodings, RAM op codes and FSM states.
package stack_ctrl_pkg;

  localparam int STK_CMD_LEN = 2;
  localparam int RAM_OP_LEN  = 3;

  typedef enum logic [STK_CMD_LEN-1:0] {
    STK_CMD_PUSH = 2'd0,
    STK_CMD_POP  = 2'd1,
    STK_CMD_CALL = 2'd2,
    STK_CMD_RET  = 2'd3
  } stk_cmd_e;

  localparam logic [RAM_OP_LEN-1:0] OP_RAM_NOP     = 3'd0;
  localparam logic [RAM_OP_LEN-1:0] OP_RAM_WR_BYTE = 3'd1;
  localparam logic [RAM_OP_LEN-1:0] OP_RAM_WR_BIT  = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR1  = 3'd1,
    ST_WR2  = 3'd2,
    ST_RD1  = 3'd3,
    ST_RD2  = 3'd4,
    ST_DONE = 3'd5
  } stk_state_e;

  function automatic logic is_write_cmd(input logic [STK_CMD_LEN-1:0] cmd);
    return (cmd == STK_CMD_PUSH) || (cmd == STK_CMD_CALL);
  endfunction

endpackage

// File: rtl/stack_ctrl.sv
// 8051 stack pointer owner: turns PUSH/POP/CALL/RET into single-byte internal RAM accesses.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] SP_RESET = 8'h07
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_req,
  input  logic [STK_CMD_LEN-1:0] i_cmd,
  input  logic [15:0]            i_wdata,
  input  logic                   i_sp_we,
  input  logic [ADDR_W-1:0]      i_sp_wdata,
  input  logic [7:0]             i_ram_byte,
  output logic                   o_ready,
  output logic                   o_done,
  output logic [15:0]            o_rdata,
  output logic [ADDR_W-1:0]      o_sp,
  output logic                   o_ovf,
  output logic                   o_unf,
  output logic                   o_sp_wr_lost,
  output logic [ADDR_W-1:0]      o_ram_addr,
  output logic [7:0]             o_ram_wr_byte,
  output logic [RAM_OP_LEN-1:0]  o_ram_op,
  output logic [ADDR_W-1:0]      o_ram_addr_r
);

  stk_state_e        state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              ovf_q, unf_q, lost_q;
  stk_cmd_e          cmd_q;
  logic [15:0]       wdata_q;
  logic [7:0]        rhi_q;
  logic              accept, wr_st, rd_st;

  always_comb begin
    state_d       = state_q;
    sp_d          = sp_q;
    rdata_d       = rdata_q;
    o_ready       = 1'b0;
    o_done        = 1'b0;
    o_ram_op      = OP_RAM_NOP;
    o_ram_addr    = '0;
    o_ram_wr_byte = '0;
    o_ram_addr_r  = '0;
    accept        = 1'b0;
    wr_st         = 1'b0;
    rd_st         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_ready = !i_sp_we;
        if (i_sp_we) begin
          sp_d = i_sp_wdata;
        end else if (i_req) begin
          accept  = 1'b1;
          state_d = is_write_cmd(i_cmd) ? ST_WR1 : ST_RD1;
        end
      end
      ST_WR1: begin
        wr_st         = 1'b1;
        o_ram_op      = OP_RAM_WR_BYTE;
        o_ram_addr    = sp_q + 1'b1;
        o_ram_wr_byte = wdata_q[7:0];
        sp_d          = sp_q + 1'b1;
        state_d       = (cmd_q == STK_CMD_CALL) ? ST_WR2 : ST_DONE;
      end
      ST_WR2: begin
        wr_st         = 1'b1;
        o_ram_op      = OP_RAM_WR_BYTE;
        o_ram_addr    = sp_q + 1'b1;
        o_ram_wr_byte = wdata_q[15:8];
        sp_d          = sp_q + 1'b1;
        state_d       = ST_DONE;
      end
      ST_RD1: begin
        rd_st        = 1'b1;
        o_ram_addr_r = sp_q;
        sp_d         = sp_q - 1'b1;
        // RET stages the high byte so o_rdata only changes on completion
        if (cmd_q == STK_CMD_RET) begin
          state_d = ST_RD2;
        end else begin
          rdata_d = {8'h00, i_ram_byte};
          state_d = ST_DONE;
        end
      end
      ST_RD2: begin
        rd_st        = 1'b1;
        o_ram_addr_r = sp_q;
        sp_d         = sp_q - 1'b1;
        rdata_d      = {rhi_q, i_ram_byte};
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      sp_q    <= SP_RESET;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      rdata_q <= rdata_d;
      ovf_q   <= wr_st && (sp_q == '1);
      unf_q   <= rd_st && (sp_q == '0);
      lost_q  <= lost_q | (i_sp_we && (state_q != ST_IDLE));
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      cmd_q   <= stk_cmd_e'(i_cmd);
      wdata_q <= i_wdata;
    end
    if (state_q == ST_RD1) rhi_q <= i_ram_byte;
  end

  assign o_rdata      = rdata_q;
  assign o_sp         = sp_q;
  assign o_ovf        = ovf_q;
  assign o_unf        = unf_q;
  assign o_sp_wr_lost = lost_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: behavioural RAM responder plus an abstract stack model.
module tb_stack_ctrl;
  import stack_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  cmd = 2'd0;
  logic [15:0] wdata = 16'h0;
  logic        sp_we = 1'b0;
  logic [7:0]  sp_wdata = 8'h0;
  logic [7:0]  ram_byte;
  logic        ready, done, ovf, unf, lost;
  logic [15:0] rdata;
  logic [7:0]  sp, ram_addr, ram_wr_byte, ram_addr_r;
  logic [2:0]  ram_op;

  stack_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_cmd(cmd), .i_wdata(wdata),
    .i_sp_we(sp_we), .i_sp_wdata(sp_wdata), .i_ram_byte(ram_byte),
    .o_ready(ready), .o_done(done), .o_rdata(rdata), .o_sp(sp), .o_ovf(ovf),
    .o_unf(unf), .o_sp_wr_lost(lost), .o_ram_addr(ram_addr),
    .o_ram_wr_byte(ram_wr_byte), .o_ram_op(ram_op), .o_ram_addr_r(ram_addr_r)
  );

  always #5 clk = ~clk;

  // RAM responder
  logic [7:0] ram [256];
  logic       bad_op = 1'b0;
  assign ram_byte = ram[ram_addr_r];
  always @(posedge clk) begin
    if (ram_op == OP_RAM_WR_BYTE) ram[ram_addr] <= ram_wr_byte;
    else if (ram_op != OP_RAM_NOP) bad_op <= 1'b1;
  end

  // reference model
  int          ref_sp;
  logic [7:0]  ref_mem [256];
  logic [15:0] ref_rdata;
  logic        ref_lost;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_model(input logic [7:0] v, inout int wraps);
    if (ref_sp == 255) wraps++;
    ref_sp = (ref_sp + 1) % 256;
    ref_mem[ref_sp] = v;
  endtask

  task automatic pop_model(output logic [7:0] v, inout int wraps);
    if (ref_sp == 0) wraps++;
    v = ref_mem[ref_sp];
    ref_sp = (ref_sp + 255) % 256;
  endtask

  task automatic run_cmd(input logic [1:0] c, input logic [15:0] v, input bit sfr_busy,
                         input string tag);
    int exp_ovf = 0, exp_unf = 0, exp_lat, lat = 0, ovfc = 0, unfc = 0;
    logic [7:0] hi, lo;
    case (c)
      2'd0: begin push_model(v[7:0], exp_ovf); exp_lat = 2; end
      2'd1: begin pop_model(lo, exp_unf); ref_rdata = {8'h00, lo}; exp_lat = 2; end
      2'd2: begin push_model(v[7:0], exp_ovf); push_model(v[15:8], exp_ovf); exp_lat = 3; end
      default: begin
        pop_model(hi, exp_unf); pop_model(lo, exp_unf); ref_rdata = {hi, lo}; exp_lat = 3;
      end
    endcase
    if (sfr_busy) ref_lost = 1'b1;
    @(negedge clk);
    req = 1'b1; cmd = c; wdata = v;
    chk({tag, "_ready"}, ready, 1'b1);
    @(posedge clk); #1;
    req = 1'b0;
    if (sfr_busy) begin sp_we = 1'b1; sp_wdata = 8'hA5; end
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 2) sp_we = 1'b0;
      ovfc += int'(ovf);
      unfc += int'(unf);
      if (done) begin lat = n; break; end
    end
    sp_we = 1'b0;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_rdata"}, rdata, ref_rdata);
    chk({tag, "_sp"}, sp, ref_sp[7:0]);
    chk({tag, "_ovf"}, ovfc, exp_ovf);
    chk({tag, "_unf"}, unfc, exp_unf);
    @(negedge clk);
    chk({tag, "_tail"}, {done, ready, ram_op, lost}, {1'b0, 1'b1, OP_RAM_NOP, ref_lost});
  endtask

  task automatic sfr_write(input logic [7:0] v);
    @(negedge clk);
    sp_we = 1'b1; sp_wdata = v;
    @(posedge clk); #1;
    sp_we = 1'b0;
    ref_sp = int'(v);
  endtask

  task automatic mem_compare(input string tag);
    int mism = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) mism++;
    chk(tag, mism, 0);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 256; i++) begin ram[i] = 8'h00; ref_mem[i] = 8'h00; end
    ref_sp = 7; ref_rdata = 16'h0; ref_lost = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {done, ovf, unf, lost, ram_op, ram_addr, ram_wr_byte, ram_addr_r},
        {4'b0, OP_RAM_NOP, 24'h0});
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sp", sp, 8'h07);
    chk("rst_ready", ready, 1'b1);
    chk("rst_rdata", rdata, 16'h0);

    run_cmd(2'd0, 16'h005A, 1'b0, "push5a");
    chk("push5a_ram08", ram[8'h08], 8'h5A);
    run_cmd(2'd1, 16'h0, 1'b0, "pop5a");

    run_cmd(2'd2, 16'h1234, 1'b0, "call1234");
    chk("call_ram", {ram[8'h08], ram[8'h09]}, 16'h3412);
    run_cmd(2'd3, 16'h0, 1'b0, "ret1234");

    sfr_write(8'hFF);
    chk("sfr_sp", sp, 8'hFF);
    run_cmd(2'd0, 16'h0077, 1'b0, "push_wrap");
    chk("push_wrap_ram00", ram[8'h00], 8'h77);
    run_cmd(2'd1, 16'h0, 1'b0, "pop_wrap");

    // SFR write beats a simultaneous request
    @(negedge clk);
    sp_we = 1'b1; sp_wdata = 8'h40; req = 1'b1; cmd = 2'd0; wdata = 16'h0099;
    #1 chk("sfr_req_ready", ready, 1'b0);
    @(posedge clk); #1;
    sp_we = 1'b0; req = 1'b0; ref_sp = 'h40;
    cnt = 0;
    repeat (4) begin @(negedge clk); if (done || ram_op != OP_RAM_NOP) cnt++; end
    chk("sfr_req_noaccept", cnt, 0);
    chk("sfr_req_sp", sp, 8'h40);

    run_cmd(2'd2, 16'hCAFE, 1'b1, "call_sfrbusy");
    run_cmd(2'd3, 16'h0, 1'b0, "ret_cafe");

    for (int k = 0; k < 40; k++) begin
      int unsigned r = $urandom_range(0, 9);
      logic [15:0] v = 16'($urandom);
      if (r == 0) sfr_write(8'($urandom));
      else if (r <= 3) run_cmd(2'd0, v, 1'b0, "rnd_push");
      else if (r == 4) run_cmd(2'd2, v, 1'b0, "rnd_call");
      else if (r <= 7) run_cmd(2'd1, v, 1'b0, "rnd_pop");
      else run_cmd(2'd3, v, 1'b0, "rnd_ret");
    end
    mem_compare("rnd_mem");

    // reset lands during WR2 of a CALL
    sfr_write(8'h07);
    @(negedge clk);
    req = 1'b1; cmd = 2'd2; wdata = 16'hBEEF;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 chk("abort_op", ram_op, OP_RAM_NOP);
    chk("abort_sp", sp, 8'h07);
    ref_mem[8'h08] = 8'hEF; ref_sp = 7; ref_rdata = 16'h0; ref_lost = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (4) begin @(negedge clk); if (done || ram_op != OP_RAM_NOP) cnt++; end
    chk("abort_nodone", cnt, 0);
    chk("abort_state", {sp, ready, lost, rdata}, {8'h07, 1'b1, 1'b0, 16'h0});
    mem_compare("abort_mem");
    chk("never_bit_op", bad_op, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
